// File: rtl/ptp_rx_parser.sv
// Receive-side PTP parser: classifies Sync / Delay_Req / Delay_Resp frames and publishes timing fields.
// Optional build macro PTP_RX_MAC_FILTER_EN drops PTP frames not addressed to MAC_ADDR or broadcast.
module ptp_rx_parser (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_data_wr,
    input  logic [133:0] in_data,
    input  logic         in_valid_wr,
    input  logic         in_valid,
    input  logic [47:0]  MAC_ADDR,
    output logic         key_valid,
    output logic [53:0]  key,
    output logic         ts_4_valid,
    output logic [47:0]  ts_4,
    output logic         sync_valid,
    output logic [47:0]  sync_t1,
    output logic [47:0]  sync_t2,
    output logic         resp_valid,
    output logic [47:0]  resp_t4,
    output logic         ptp_rcv_type_valid,
    output logic [3:0]   ptp_rcv_type,
    output logic [31:0]  rx_sync_cnt,
    output logic [31:0]  rx_req_cnt,
    output logic [31:0]  rx_resp_cnt,
    output logic [31:0]  rx_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_SKIP1, S_ETH, S_BODY, S_TAIL_WAIT, S_DROP
    } state_t;

    typedef enum logic [1:0] {CLS_SYNC, CLS_REQ, CLS_RESP} cls_t;

    localparam logic [1:0]  WT_HEAD  = 2'b01;
    localparam logic [1:0]  WT_TAIL  = 2'b10;
    localparam logic [15:0] ETH_PTP  = 16'h88F7;
    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

    state_t      state, next_state;
    cls_t        cls_q, eth_cls;
    logic [5:0]  port_q;
    logic [47:0] head_ts_q, src_mac_q;
    logic        body_cnt_q;

    logic        is_head, is_tail;
    logic        eth_ok, dst_ok;
    logic        head_load, eth_load, body_inc, commit, err_inc;
    logic [47:0] dst_mac, src_mac, tail_ts;
    logic [15:0] ethertype, type_ver;
    logic        unused_bits;

    assign is_head   = in_data_wr && (in_data[133:132] == WT_HEAD);
    assign is_tail   = in_data_wr && (in_data[133:132] == WT_TAIL);
    assign dst_mac   = in_data[127:80];
    assign src_mac   = in_data[79:32];
    assign ethertype = in_data[31:16];
    assign type_ver  = in_data[15:0];
    assign tail_ts   = in_data[95:48];
    assign unused_bits = ^{in_data[131:126], dst_mac, MAC_ADDR};

`ifdef PTP_RX_MAC_FILTER_EN
    assign dst_ok = (dst_mac == MAC_ADDR) || (dst_mac == MAC_BCAST);
`else
    assign dst_ok = 1'b1;
`endif

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        eth_cls = CLS_SYNC;
        eth_ok  = 1'b0;
        if (ethertype == ETH_PTP && dst_ok) begin
            eth_ok = 1'b1;
            case (type_ver)
                16'h0101: eth_cls = CLS_SYNC;
                16'h0301: eth_cls = CLS_REQ;
                16'h0401: eth_cls = CLS_RESP;
                default:  eth_ok  = 1'b0;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        head_load  = 1'b0;
        eth_load   = 1'b0;
        body_inc   = 1'b0;
        commit     = 1'b0;
        err_inc    = 1'b0;
        if (is_head) begin
            // A head always restarts parsing; outside IDLE it aborts the current frame.
            head_load  = 1'b1;
            next_state = S_SKIP1;
            err_inc    = (state != S_IDLE);
        end else if (in_data_wr) begin
            case (state)
                S_IDLE: err_inc = 1'b1;
                S_SKIP1: begin
                    next_state = is_tail ? S_IDLE : S_ETH;
                    err_inc    = is_tail;
                end
                S_ETH: begin
                    if (is_tail) begin
                        next_state = S_IDLE;
                        err_inc    = 1'b1;
                    end else if (eth_ok) begin
                        next_state = S_BODY;
                        eth_load   = 1'b1;
                    end else begin
                        next_state = S_DROP;
                    end
                end
                S_BODY: begin
                    if (is_tail) begin
                        next_state = S_IDLE;
                        err_inc    = 1'b1;
                    end else if (body_cnt_q) begin
                        next_state = S_TAIL_WAIT;
                    end else begin
                        body_inc = 1'b1;
                    end
                end
                S_TAIL_WAIT: begin
                    if (is_tail) begin
                        next_state = S_IDLE;
                        commit     = in_valid_wr && in_valid;
                        err_inc    = !(in_valid_wr && in_valid);
                    end
                end
                S_DROP: if (is_tail) next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cls_q      <= CLS_SYNC;
            port_q     <= '0;
            head_ts_q  <= '0;
            src_mac_q  <= '0;
            body_cnt_q <= 1'b0;
        end else begin
            state <= next_state;
            if (head_load) begin
                port_q    <= in_data[125:120];
                head_ts_q <= in_data[47:0];
            end
            if (eth_load) begin
                src_mac_q  <= src_mac;
                cls_q      <= eth_cls;
                body_cnt_q <= 1'b0;
            end else if (body_inc) begin
                body_cnt_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid          <= 1'b0;
            key                <= '0;
            ts_4_valid         <= 1'b0;
            ts_4               <= '0;
            sync_valid         <= 1'b0;
            sync_t1            <= '0;
            sync_t2            <= '0;
            resp_valid         <= 1'b0;
            resp_t4            <= '0;
            ptp_rcv_type_valid <= 1'b0;
            ptp_rcv_type       <= '0;
            rx_sync_cnt        <= '0;
            rx_req_cnt         <= '0;
            rx_resp_cnt        <= '0;
            rx_err_cnt         <= '0;
        end else begin
            key_valid          <= 1'b0;
            ts_4_valid         <= 1'b0;
            sync_valid         <= 1'b0;
            resp_valid         <= 1'b0;
            ptp_rcv_type_valid <= 1'b0;
            if (err_inc) rx_err_cnt <= rx_err_cnt + 32'd1;
            if (commit) begin
                ptp_rcv_type_valid <= 1'b1;
                case (cls_q)
                    CLS_SYNC: begin
                        sync_valid   <= 1'b1;
                        sync_t1      <= tail_ts;
                        sync_t2      <= head_ts_q;
                        ptp_rcv_type <= 4'd1;
                        rx_sync_cnt  <= rx_sync_cnt + 32'd1;
                    end
                    CLS_REQ: begin
                        key_valid    <= 1'b1;
                        ts_4_valid   <= 1'b1;
                        key          <= {src_mac_q, port_q};
                        ts_4         <= head_ts_q;
                        ptp_rcv_type <= 4'd3;
                        rx_req_cnt   <= rx_req_cnt + 32'd1;
                    end
                    CLS_RESP: begin
                        resp_valid   <= 1'b1;
                        resp_t4      <= tail_ts;
                        ptp_rcv_type <= 4'd4;
                        rx_resp_cnt  <= rx_resp_cnt + 32'd1;
                    end
                    default: ptp_rcv_type_valid <= 1'b0;
                endcase
            end
        end
    end

endmodule
